// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C slave register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] slave_addr);
    return (addr_byte[7:1] == slave_addr);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Per-line synchroniser with edge detect; I2C_GLITCH_FILTER_EN adds a 3-sample stability filter.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic line_s;

  // Two-stage synchroniser, preset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic hist1_q;
  logic hist2_q;

  // Sample history for the stability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  // Filtered level follows the input only after three equal samples.
  always_comb begin
    if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
      line_s = sync2_q;
    end else begin
      line_s = prev_q;
    end
  end
`else
  // Unfiltered level is the synchroniser output.
  always_comb begin
    line_s = sync2_q;
  end
`endif

  // Delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= line_s;
    end
  end

  assign level_o = line_s;
  assign rise_o  = line_s & ~prev_q;
  assign fall_o  = ~line_s & prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a DEPTH x 8 register file with byte pointer and host-side port.
// Optional macro I2C_GLITCH_FILTER_EN enables the input glitch filter in i2c_line_sync.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         DEPTH      = 16,
  parameter logic [7:0] RESET_VAL  = 8'h00,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] host_addr,
  input  logic             host_we,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             busy,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_ptr
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (scl_i),
    .level_o(scl_lvl_s),
    .rise_o (scl_rise_s),
    .fall_o (scl_fall_s)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (sda_i),
    .level_o(sda_lvl_s),
    .rise_o (sda_rise_s),
    .fall_o (sda_fall_s)
  );

  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;

  i2c_state_e       state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             ack_on_q, ack_on_d;
  logic             mack_q, mack_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_pulse_q, wr_pulse_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             bus_we_s;
  logic [7:0]       shift_in_s;
  logic [7:0]       rd_byte_s;
  logic [7:0]       regs_q [DEPTH];

  assign shift_in_s = {shift_q[6:0], sda_lvl_s};
  assign rd_byte_s  = regs_q[ptr_q];

  // Protocol FSM: START/STOP take priority, data sampled on SCL rise, SDA driven on SCL fall.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_on_d   = ack_on_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    bus_we_s   = 1'b0;
    if (start_s) begin
      state_d  = ADDR;
      bitcnt_d = 3'd7;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shift_d  = shift_in_s;
            bitcnt_d = bitcnt_q - 3'd1;
            if (bitcnt_q != 3'd0) begin
              state_d = state_q;
            end else if (state_q == ADDR) begin
              if (addr_match(shift_in_s, SLAVE_ADDR)) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_in_s[0];
              end else begin
                state_d  = IDLE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d   = shift_in_s[PTR_W-1:0];
              state_d = PTR_ACK;
            end else begin
              bus_we_s   = 1'b1;
              wr_pulse_d = 1'b1;
              wr_ptr_d   = ptr_q;
              ptr_d      = ptr_q + PTR_W'(1);
              state_d    = WDATA_ACK;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First fall asserts ACK, second fall ends the ACK clock.
          if (!scl_fall_s) begin
            ack_on_d = ack_on_q;
          end else if (!ack_on_q) begin
            sda_oe_d = ~ACK;
            ack_on_d = 1'b1;
          end else begin
            ack_on_d = 1'b0;
            bitcnt_d = 3'd7;
            if ((state_q == ADDR_ACK) && rw_q) begin
              shift_d  = rd_byte_s;
              sda_oe_d = ~rd_byte_s[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          if (!scl_fall_s) begin
            bitcnt_d = bitcnt_q;
          end else if (bitcnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + PTR_W'(1);
            state_d  = RDATA_ACK;
          end else begin
            bitcnt_d = bitcnt_q - 3'd1;
            sda_oe_d = ~shift_q[bitcnt_q - 3'd1];
          end
        end
        RDATA_ACK: begin
          if (scl_rise_s) begin
            mack_d = sda_lvl_s;
          end else if (scl_fall_s) begin
            if (mack_q == ACK) begin
              shift_d  = rd_byte_s;
              sda_oe_d = ~rd_byte_s[7];
              bitcnt_d = 3'd7;
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end else begin
            mack_d = mack_q;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd7;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      mack_q     <= NACK;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_on_q   <= ack_on_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Register file; the host write is last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      if (bus_we_s) begin
        regs_q[ptr_q] <= shift_in_s;
      end
      if (host_we) begin
        regs_q[host_addr] <= host_wdata;
      end
    end
  end

  assign host_rdata = regs_q[host_addr];
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: bit-banged I2C master against an array/pointer model of the register file.
module tb_i2c_slave_regfile;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       busy;
  logic       wr_pulse;
  logic [3:0] wr_ptr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [16];
  logic [3:0] mptr;
  logic [3:0] wr_log [256];
  int         wr_cnt = 0;
  int         oe_cnt = 0;
  logic       coll_pulse;

  always #5 clk = ~clk;
  assign sda_line = m_sda & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h2A), .DEPTH(16), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .wr_pulse(wr_pulse), .wr_ptr(wr_ptr)
  );

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      wr_log[wr_cnt[7:0]] = wr_ptr;
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe === 1'b1) oe_cnt = oe_cnt + 1;
  end

  task automatic bit_xfer(input logic b, input bit coll, output logic s);
    s = 1'b1;
    m_sda = b;
    repeat (6) @(negedge clk);
    scl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      host_we = coll && (i == LAT - 2);
      if (coll && (i == LAT - 1)) coll_pulse = wr_pulse;
      if (i == 3) s = sda_line;
    end
    scl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic i2c_start;
    if (scl == 1'b0) begin
      m_sda = 1'b1;
      repeat (8) @(negedge clk);
      scl = 1'b1;
      repeat (6) @(negedge clk);
    end
    m_sda = 1'b0;
    repeat (6) @(negedge clk);
    scl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0;
    repeat (8) @(negedge clk);
    scl = 1'b1;
    repeat (6) @(negedge clk);
    m_sda = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit coll, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], coll && (i == 0), s);
    bit_xfer(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic master_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_xfer(master_bit, 1'b0, s);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
    host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_pulse !== 1'b0 || wr_ptr !== 4'd0) begin errors++; $display("FAIL reset_wr got %b/%0d want 0/0", wr_pulse, wr_ptr); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); host_addr = i[3:0]; #1;
      checks++; if (host_rdata !== mem[i]) begin errors++; $display("FAIL reset_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
  endtask

  task automatic test_write_burst;
    logic a0, a1, a2, a3;
    int w0;
    w0 = wr_cnt;
    i2c_start;
    send_byte(8'h54, 1'b0, a0);
    send_byte(8'h03, 1'b0, a1);
    send_byte(8'hA5, 1'b0, a2);
    send_byte(8'h5A, 1'b0, a3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wb_busy got %b want 1", busy); end
    i2c_stop;
    mem[3] = 8'hA5; mem[4] = 8'h5A; mptr = 4'd5;
    checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL wb_acks got %b want 1111", {a0, a1, a2, a3}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_busy_stop got %b want 0", busy); end
    checks++;
    if (wr_cnt - w0 != 2 || wr_log[w0[7:0]] !== 4'd3 || wr_log[w0[7:0] + 8'd1] !== 4'd4) begin
      errors++; $display("FAIL wb_wr_pulse got count %0d want 2 with ptrs 3,4", wr_cnt - w0);
    end
    for (int i = 3; i < 5; i++) begin
      @(negedge clk); host_addr = i[3:0]; #1;
      checks++; if (host_rdata !== mem[i]) begin errors++; $display("FAIL wb_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
  endtask

  task automatic test_wrap_read;
    logic a0, a1, a2;
    logic [7:0] d;
    logic [7:0] exp_b;
    host_write(4'd15, 8'($urandom_range(1, 255)));
    host_write(4'd0, 8'($urandom_range(1, 255)));
    host_write(4'd1, 8'($urandom_range(1, 255)));
    i2c_start;
    send_byte(8'h54, 1'b0, a0);
    send_byte(8'h0F, 1'b0, a1);
    mptr = 4'd15;
    i2c_start;
    send_byte(8'h55, 1'b0, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wr_acks got %b want 111", {a0, a1, a2}); end
    for (int j = 0; j < 3; j++) begin
      exp_b = mem[mptr];
      recv_byte((j == 2) ? 1'b1 : 1'b0, d);
      mptr = mptr + 4'd1;
      checks++; if (d !== exp_b) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", j, d, exp_b); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy_nack got %b want 1", busy); end
    i2c_stop;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_mismatch;
    logic a0;
    int o0;
    o0 = oe_cnt;
    i2c_start;
    send_byte(8'h56, 1'b0, a0);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL mm_ack got %b want 0", a0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %b want 0", busy); end
    send_byte(8'hFF, 1'b0, a0);
    i2c_stop;
    checks++; if (oe_cnt != o0) begin errors++; $display("FAIL mm_sda_oe got %0d driven cycles want 0", oe_cnt - o0); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); host_addr = i[3:0]; #1;
      checks++; if (host_rdata !== mem[i]) begin errors++; $display("FAIL mm_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
  endtask

  task automatic test_collision;
    logic a0, a1, a2;
    int w0;
    i2c_start;
    send_byte(8'h54, 1'b0, a0);
    send_byte(8'h04, 1'b0, a1);
    host_addr = 4'd4; host_wdata = 8'h11; coll_pulse = 1'b0;
    w0 = wr_cnt;
    send_byte(8'h22, 1'b1, a2);
    i2c_stop;
    mem[4] = 8'h11; mptr = 4'd5;
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL coll_acks got %b want 111", {a0, a1, a2}); end
    checks++; if (coll_pulse !== 1'b1) begin errors++; $display("FAIL coll_pulse got %b want 1", coll_pulse); end
    checks++; if (wr_cnt - w0 != 1 || wr_log[w0[7:0]] !== 4'd4) begin errors++; $display("FAIL coll_wr_ptr got count %0d want 1 at ptr 4", wr_cnt - w0); end
    @(negedge clk); host_addr = 4'd4; #1;
    checks++; if (host_rdata !== 8'h11) begin errors++; $display("FAIL coll_reg4 got %h want 11", host_rdata); end
  endtask

  task automatic test_reset_midrun;
    logic s, a0, a1;
    bit seen;
    logic [7:0] d;
    seen = 1'b0;
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_xfer(s_bit(8'h54, i), 1'b0, s);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (sda_oe === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_ack_timeout got no sda_oe want 1 within 20 clk"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); host_addr = i[3:0]; #1;
      checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL mid_reg[%0d] got %h want 00", i, host_rdata); end
    end
    d = 8'($urandom);
    i2c_start;
    send_byte(8'h54, 1'b0, a0);
    send_byte(8'h07, 1'b0, a1);
    send_byte(d, 1'b0, s);
    i2c_stop;
    mem[7] = d; mptr = 4'd8;
    checks++; if ({a0, a1, s} !== 3'b111) begin errors++; $display("FAIL mid_post_acks got %b want 111", {a0, a1, s}); end
    @(negedge clk); host_addr = 4'd7; #1;
    checks++; if (host_rdata !== d) begin errors++; $display("FAIL mid_post_reg7 got %h want %h", host_rdata, d); end
  endtask

  function automatic logic s_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

  task automatic test_random;
    logic a;
    logic [7:0] d, pb, exp_b;
    logic [3:0] exp_wr [3];
    int n, w0;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 3);
      i2c_start;
      if ($urandom_range(0, 1) == 0) begin
        pb = 8'($urandom_range(0, 255));
        w0 = wr_cnt;
        send_byte(8'h54, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rnd%0d_waddr_ack got %b want 1", t, a); end
        send_byte(pb, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rnd%0d_ptr_ack got %b want 1", t, a); end
        mptr = pb[3:0];
        for (int j = 0; j < n; j++) begin
          d = 8'($urandom);
          send_byte(d, 1'b0, a);
          checks++; if (a !== 1'b1) begin errors++; $display("FAIL rnd%0d_data_ack got %b want 1", t, a); end
          mem[mptr] = d; exp_wr[j] = mptr; mptr = mptr + 4'd1;
        end
        i2c_stop;
        checks++; if (wr_cnt - w0 != n) begin errors++; $display("FAIL rnd%0d_wr_count got %0d want %0d", t, wr_cnt - w0, n); end
        for (int j = 0; j < n; j++) begin
          checks++;
          if (wr_log[w0[7:0] + j[7:0]] !== exp_wr[j]) begin
            errors++; $display("FAIL rnd%0d_wr_ptr%0d got %0d want %0d", t, j, wr_log[w0[7:0] + j[7:0]], exp_wr[j]);
          end
        end
      end else begin
        send_byte(8'h55, 1'b0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rnd%0d_raddr_ack got %b want 1", t, a); end
        for (int j = 0; j < n; j++) begin
          exp_b = mem[mptr];
          recv_byte((j == n - 1) ? 1'b1 : 1'b0, d);
          mptr = mptr + 4'd1;
          checks++; if (d !== exp_b) begin errors++; $display("FAIL rnd%0d_rd%0d got %h want %h", t, j, d, exp_b); end
        end
        i2c_stop;
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); host_addr = i[3:0]; #1;
      checks++; if (host_rdata !== mem[i]) begin errors++; $display("FAIL rnd_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch;
    logic a;
    @(negedge clk);
    m_sda = 1'b0;
    repeat (2) @(negedge clk);
    m_sda = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    scl = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h54, 1'b0, a);
    i2c_stop;
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL glitch_ack got %b want 0", a); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_burst;
    test_wrap_read;
    test_mismatch;
    test_collision;
    test_reset_midrun;
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
